// File: rtl/angle_sweep_pkg.sv
// Shared state type, angle limits and per-stage sweep tables for the
// coarse-to-fine pose search sequencer.
package angle_sweep_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSweep,
        StWaitSort,
        StDone
    } state_e;

    localparam int unsigned THETA_LIM = 300;
    localparam int unsigned PHI_LIM   = 1800;
    localparam int unsigned ALPHA_LIM = 3600;

    // Indexed by stage. Entries past stage 3 repeat the finest settings so any
    // NUM_STAGES up to 8 is well defined. Stage 0 sweeps the full range, so its
    // window entries are unused.
    localparam int unsigned DELTA_THETA     [8] = '{10, 10, 5, 1, 1, 1, 1, 1};
    localparam int unsigned DELTA_PHI       [8] = '{40, 20, 10, 2, 2, 2, 2, 2};
    localparam int unsigned THETA_WIN       [8] = '{0, 20, 10, 2, 2, 2, 2, 2};
    localparam int unsigned PHI_WIN         [8] = '{0, 40, 20, 4, 4, 4, 4, 4};
    localparam int unsigned ALPHA_STEP      [8] = '{200, 60, 30, 10, 10, 10, 10, 10};
    localparam int unsigned CAND_NUM        [8] = '{1, 10, 6, 3, 3, 3, 3, 3};
    localparam int unsigned COMPARE_NUM     [8] = '{10, 6, 3, 1, 1, 1, 1, 1};
    localparam int unsigned SCORE_ALPHA_NUM [8] = '{18, 60, 120, 360, 360, 360, 360, 360};

endpackage

// File: rtl/angle_axis_counter.sv
// One sweep axis: latches [min, max] and a step, walks min..max with the final
// step clamped onto max (so max is always visited), then wraps back to min.
module angle_axis_counter #(
    parameter int unsigned ANG_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [ANG_W-1:0] min_val,
    input  logic [ANG_W-1:0] max_val,
    input  logic [ANG_W-1:0] delta,
    output logic [ANG_W-1:0] value,
    output logic             last
);

    logic [ANG_W-1:0] val_q, val_d;
    logic [ANG_W-1:0] min_q, min_d;
    logic [ANG_W-1:0] max_q, max_d;
    logic [ANG_W-1:0] delta_q, delta_d;
    logic [ANG_W:0]   sum;

    // Next value: load bounds, or advance with clamp to max and wrap after max.
    always_comb begin
        val_d   = val_q;
        min_d   = min_q;
        max_d   = max_q;
        delta_d = delta_q;
        sum     = {1'b0, val_q} + {1'b0, delta_q};
        if (load) begin
            min_d   = min_val;
            max_d   = max_val;
            delta_d = delta;
            val_d   = min_val;
        end else if (step) begin
            if (last) begin
                val_d = min_q;
            end else if (sum > {1'b0, max_q}) begin
                val_d = max_q;
            end else begin
                val_d = sum[ANG_W-1:0];
            end
        end
    end

    // Axis registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            delta_q <= '0;
        end else begin
            val_q   <= val_d;
            min_q   <= min_d;
            max_q   <= max_d;
            delta_q <= delta_d;
        end
    end

    assign value = val_q;
    assign last  = (val_q == max_q);

endmodule

// File: rtl/angle_sweep_controller.sv
// Coarse-to-fine pose search sequencer: emits (theta, phi, alpha) tuples with
// valid/ready over NUM_STAGES stages; stages after 0 sweep a clamped window
// around each sorted candidate.
module angle_sweep_controller
    import angle_sweep_pkg::*;
#(
    parameter int unsigned ANG_W      = 12,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned MAX_CAND   = 10,
    parameter int unsigned CAND_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [MAX_CAND*2*ANG_W-1:0]   cand_buf,
    input  logic                          sorted_rdy,
    input  logic                          angle_ready,
    output logic                          angle_valid,
    output logic [ANG_W-1:0]              theta,
    output logic [ANG_W-1:0]              phi,
    output logic [ANG_W-1:0]              alpha,
    output logic                          last_of_cand,
    output logic                          last_of_stage,
    output logic [2:0]                    stage_idx,
    output logic [CAND_W-1:0]             cand_idx,
    output logic [3:0]                    compare_num,
    output logic [8:0]                    score_alpha_num,
    output logic                          stage_start,
    output logic                          search_done
);

    state_e            state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [CAND_W-1:0] cand_q, cand_d;
    logic [CAND_W-1:0] cand_last;
    logic              sweeping, load, fire, cand_end;
    logic [ANG_W-1:0]  c_theta, c_phi, t_min, t_max, p_min, p_max, a_step;
    logic [ANG_W-1:0]  th_val, ph_val, al_val;
    logic              th_last, ph_last, al_last;

    function automatic logic [ANG_W-1:0] win_lo(input logic [ANG_W-1:0] c,
                                                input logic [ANG_W-1:0] w);
        return (c > w) ? c - w : '0;
    endfunction

    // Sum is one bit wider so a window near the top clamps instead of wrapping.
    function automatic logic [ANG_W-1:0] win_hi(input logic [ANG_W-1:0] c,
                                                input logic [ANG_W-1:0] w,
                                                input logic [ANG_W-1:0] lim);
        logic [ANG_W:0] s;
        s = {1'b0, c} + {1'b0, w};
        return (s > {1'b0, lim}) ? lim : s[ANG_W-1:0];
    endfunction

    assign sweeping = (state_q == StSweep);
    assign load     = (state_q == StLoad);
    assign fire     = sweeping && angle_ready;
    assign cand_end = th_last && ph_last && al_last;
    assign a_step   = ANG_W'(ALPHA_STEP[stage_q]);

    // Last candidate slot of the current stage, limited by the buffer size.
    always_comb begin
        cand_last = '0;
        if (stage_q != 3'd0) begin
            if (CAND_NUM[stage_q] > MAX_CAND) begin
                cand_last = CAND_W'(MAX_CAND - 1);
            end else begin
                cand_last = CAND_W'(CAND_NUM[stage_q] - 1);
            end
        end
    end

    // Select the current candidate slot and derive its clamped sweep bounds.
    always_comb begin
        c_theta = '0;
        c_phi   = '0;
        for (int k = 0; k < int'(MAX_CAND); k++) begin
            if (cand_q == CAND_W'(k)) begin
                c_theta = cand_buf[k*2*ANG_W + 2*ANG_W - 1 -: ANG_W];
                c_phi   = cand_buf[k*2*ANG_W + ANG_W - 1 -: ANG_W];
            end
        end
        if (stage_q == 3'd0) begin
            t_min = '0;
            t_max = ANG_W'(THETA_LIM);
            p_min = '0;
            p_max = ANG_W'(PHI_LIM);
        end else begin
            t_min = win_lo(c_theta, ANG_W'(THETA_WIN[stage_q]));
            t_max = win_hi(c_theta, ANG_W'(THETA_WIN[stage_q]), ANG_W'(THETA_LIM));
            p_min = win_lo(c_phi, ANG_W'(PHI_WIN[stage_q]));
            p_max = win_hi(c_phi, ANG_W'(PHI_WIN[stage_q]), ANG_W'(PHI_LIM));
        end
    end

    // Alpha is innermost, then phi, then theta.
    angle_axis_counter #(.ANG_W(ANG_W)) u_theta (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (fire && al_last && ph_last),
        .min_val (t_min),
        .max_val (t_max),
        .delta   (ANG_W'(DELTA_THETA[stage_q])),
        .value   (th_val),
        .last    (th_last)
    );

    angle_axis_counter #(.ANG_W(ANG_W)) u_phi (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (fire && al_last),
        .min_val (p_min),
        .max_val (p_max),
        .delta   (ANG_W'(DELTA_PHI[stage_q])),
        .value   (ph_val),
        .last    (ph_last)
    );

    angle_axis_counter #(.ANG_W(ANG_W)) u_alpha (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (fire),
        .min_val (a_step),
        .max_val (ANG_W'(ALPHA_LIM)),
        .delta   (a_step),
        .value   (al_val),
        .last    (al_last)
    );

    // Sequencer next state; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cand_d  = cand_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    stage_d = '0;
                    cand_d  = '0;
                end
            end
            StLoad: state_d = StSweep;
            StSweep: begin
                if (fire && cand_end) begin
                    if (cand_q == cand_last) begin
                        state_d = StWaitSort;
                    end else begin
                        cand_d  = cand_q + 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            StWaitSort: begin
                if (sorted_rdy) begin
                    if (stage_q == 3'(NUM_STAGES - 1)) begin
                        state_d = StDone;
                    end else begin
                        stage_d = stage_q + 3'd1;
                        cand_d  = '0;
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            stage_d = '0;
            cand_d  = '0;
        end
    end

    // Sequencer state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cand_q  <= cand_d;
        end
    end

    // Tuple outputs read zero outside SWEEP so IDLE presents all-zero outputs.
    assign angle_valid     = sweeping;
    assign theta           = sweeping ? th_val : '0;
    assign phi             = sweeping ? ph_val : '0;
    assign alpha           = sweeping ? al_val : '0;
    assign last_of_cand    = sweeping && cand_end;
    assign last_of_stage   = last_of_cand && (cand_q == cand_last);
    assign stage_idx       = stage_q;
    assign cand_idx        = cand_q;
    assign compare_num     = (state_q != StIdle) ? 4'(COMPARE_NUM[stage_q]) : 4'd0;
    assign score_alpha_num = (state_q != StIdle) ? 9'(SCORE_ALPHA_NUM[stage_q]) : 9'd0;
    assign stage_start     = load && (cand_q == '0);
    assign search_done     = (state_q == StDone);

endmodule

// File: tb/tb_angle_sweep_controller.sv
// Randomized bench for angle_sweep_controller: a tuple-list reference model
// built from the sweep rules, plus a reduced NUM_STAGES=2/MAX_CAND=4 instance.
module tb_angle_sweep_controller;

    localparam int ANG_W = 12;
    localparam int MAXC  = 10;
    localparam int NS    = 4;
    localparam int TLIM  = 300;
    localparam int PLIM  = 1800;
    localparam int ALIM  = 3600;

    int d_theta [4] = '{10, 10, 5, 1};
    int d_phi   [4] = '{40, 20, 10, 2};
    int t_win   [4] = '{0, 20, 10, 2};
    int p_win   [4] = '{0, 40, 20, 4};
    int a_stp   [4] = '{200, 60, 30, 10};
    int c_num   [4] = '{1, 10, 6, 3};
    int cmp_n   [4] = '{10, 6, 3, 1};
    int san     [4] = '{18, 60, 120, 360};

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  ci;
        logic [11:0] th;
        logic [11:0] ph;
        logic [11:0] al;
        logic        loc;
        logic        los;
    } tup_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, start, abort, sorted_rdy, angle_ready;
    logic [MAXC*2*ANG_W-1:0] cand_buf;
    logic                    angle_valid, last_of_cand, last_of_stage, stage_start, search_done;
    logic [ANG_W-1:0]        theta, phi, alpha;
    logic [2:0]              stage_idx;
    logic [3:0]              cand_idx, compare_num;
    logic [8:0]              score_alpha_num;

    angle_sweep_controller dut (
        .clk (clk), .rst (rst), .start (start), .abort (abort), .cand_buf (cand_buf),
        .sorted_rdy (sorted_rdy), .angle_ready (angle_ready), .angle_valid (angle_valid),
        .theta (theta), .phi (phi), .alpha (alpha), .last_of_cand (last_of_cand),
        .last_of_stage (last_of_stage), .stage_idx (stage_idx), .cand_idx (cand_idx),
        .compare_num (compare_num), .score_alpha_num (score_alpha_num),
        .stage_start (stage_start), .search_done (search_done)
    );

    // Reduced build: two stages, four candidate slots.
    logic              rst2, start2, abort2, sorted2, ready2;
    logic [4*2*12-1:0] cand_buf2;
    logic              valid2, loc2, los2, ss2, done2;
    logic [11:0]       th2, ph2, al2;
    logic [2:0]        st2;
    logic [3:0]        ci2, cmp2;
    logic [8:0]        san2;

    angle_sweep_controller #(.NUM_STAGES(2), .MAX_CAND(4), .CAND_W(4)) dut2 (
        .clk (clk), .rst (rst2), .start (start2), .abort (abort2), .cand_buf (cand_buf2),
        .sorted_rdy (sorted2), .angle_ready (ready2), .angle_valid (valid2),
        .theta (th2), .phi (ph2), .alpha (al2), .last_of_cand (loc2),
        .last_of_stage (los2), .stage_idx (st2), .cand_idx (ci2),
        .compare_num (cmp2), .score_alpha_num (san2),
        .stage_start (ss2), .search_done (done2)
    );

    int   checks = 0;
    int   errors = 0;
    tup_t exp_q[$];
    int   cth [MAXC];
    int   cph [MAXC];
    bit   mon_en = 1'b0;
    bit   hold_prev = 1'b0;
    int   exp_stage = 0;
    int   ss_count = 0;
    bit   t6_finished = 1'b0;

    tup_t        cur_tup;
    logic [63:0] outs1;
    assign cur_tup = {stage_idx, cand_idx, theta, phi, alpha, last_of_cand, last_of_stage};
    assign outs1   = {3'd0, angle_valid, theta, phi, alpha, last_of_cand, last_of_stage,
                      stage_idx, cand_idx, compare_num, score_alpha_num, stage_start,
                      search_done};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Next value on an axis, clamped to hi; returns hi+1 once hi was visited.
    function automatic int step_to(input int cur, input int d, input int hi);
        if (cur == hi) return hi + 1;
        return (cur + d > hi) ? hi : cur + d;
    endfunction

    function automatic int axis_count(input int lo, input int hi, input int d);
        return (hi - lo + d - 1) / d + 1;
    endfunction

    // Expected tuple list for one stage from the current candidate values.
    function automatic void build_stage(input int s);
        int   nc, tmin, tmax, pmin, pmax;
        tup_t e;
        nc = (s == 0) ? 1 : c_num[s];
        for (int k = 0; k < nc; k++) begin
            if (s == 0) begin
                tmin = 0; tmax = TLIM; pmin = 0; pmax = PLIM;
            end else begin
                tmin = (cth[k] > t_win[s]) ? cth[k] - t_win[s] : 0;
                tmax = (cth[k] + t_win[s] > TLIM) ? TLIM : cth[k] + t_win[s];
                pmin = (cph[k] > p_win[s]) ? cph[k] - p_win[s] : 0;
                pmax = (cph[k] + p_win[s] > PLIM) ? PLIM : cph[k] + p_win[s];
            end
            for (int t = tmin; t <= tmax; t = step_to(t, d_theta[s], tmax))
                for (int p = pmin; p <= pmax; p = step_to(p, d_phi[s], pmax))
                    for (int a = a_stp[s]; a <= ALIM; a = step_to(a, a_stp[s], ALIM)) begin
                        e.st  = 3'(s);
                        e.ci  = 4'(k);
                        e.th  = 12'(t);
                        e.ph  = 12'(p);
                        e.al  = 12'(a);
                        e.loc = (t == tmax) && (p == pmax) && (a == ALIM);
                        e.los = e.loc && (k == nc - 1);
                        exp_q.push_back(e);
                    end
        end
    endfunction

    // Candidates sit on a range edge (cheap, clamped windows); stage 1 adds
    // two interior/near-edge theta slots.
    task automatic set_cands(input int s);
        for (int k = 0; k < MAXC; k++) begin
            cth[k] = ($urandom_range(0, 1) != 0) ? TLIM : 0;
            cph[k] = ($urandom_range(0, 1) != 0) ? PLIM : 0;
        end
        if (s == 1) begin
            cth[0] = 5;
            cth[1] = 295;
        end
        for (int k = 0; k < MAXC; k++) begin
            cand_buf[k*24 + 23 -: 12] = 12'(cth[k]);
            cand_buf[k*24 + 11 -: 12] = 12'(cph[k]);
        end
    endtask

    // Scoreboard: every visible tuple must match the head of the expected list.
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_prev) check_eq("hold_valid", 64'(angle_valid), 64'd1);
            if (angle_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_tuple", 64'(exp_q.size()), 64'd1);
                end else begin
                    check_eq("tuple", 64'(cur_tup), 64'(exp_q[0]));
                    if (angle_ready) void'(exp_q.pop_front());
                end
            end
            hold_prev = angle_valid && !angle_ready;
            if (stage_start) begin
                check_eq("stage_start", 64'({stage_idx, cand_idx, compare_num, score_alpha_num}),
                         64'({3'(exp_stage), 4'd0, 4'(cmp_n[exp_stage]), 9'(san[exp_stage])}));
                ss_count++;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Drive random backpressure and ignored pulses until the stage list drains.
    task automatic run_stage();
        int stall_at, stall_left;
        bit drained;
        stall_at   = $urandom_range(100, 2000);
        stall_left = 0;
        drained    = 1'b0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                angle_ready = 1'b0;
                stall_left--;
            end else if (cyc == stall_at) begin
                angle_ready = 1'b0;
                stall_left  = 4;
            end else begin
                angle_ready = ($urandom_range(0, 7) != 0);
            end
            sorted_rdy = (exp_q.size() > 50) && ($urandom_range(0, 63) == 0);
            start      = (exp_q.size() > 50) && ($urandom_range(0, 63) == 0);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        sorted_rdy = 1'b0;
        start      = 1'b0;
        if (!drained) check_eq("stage_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_pops(input int n);
        int  target;
        bit  hit;
        target = exp_q.size() - n;
        hit    = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(posedge clk);
            #1;
            angle_ready = 1'b1;
            if (exp_q.size() <= target) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check_eq("pop_timeout", 64'(exp_q.size()), 64'(target));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; sorted_rdy = 1'b0;
        angle_ready = 1'b0; cand_buf = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", outs1, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("idle_outputs", outs1, 64'd0);

        // Full four-stage search.
        for (int s = 0; s < NS; s++) begin
            if (s == 0) begin
                build_stage(0);
                exp_stage = 0;
                mon_en    = 1'b1;
                @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            run_stage();
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check_eq("wait_sort_idle", 64'({angle_valid, search_done}), 64'd0);
            end
            @(posedge clk);
            #1;
            if (s < NS - 1) begin
                set_cands(s + 1);
                build_stage(s + 1);
                exp_stage = s + 1;
            end
            sorted_rdy = 1'b1;
            @(posedge clk);
            #1 sorted_rdy = 1'b0;
            @(negedge clk);
            check_eq("search_done", 64'(search_done), 64'(s == NS - 1));
        end
        check_eq("stage_start_count", 64'(ss_count), 64'(NS));
        repeat (2) @(negedge clk);
        check_eq("done_hold", 64'({search_done, angle_valid}), 64'b10);

        // Restart from DONE, then abort mid-sweep.
        exp_q.delete();
        build_stage(0);
        exp_stage = 0;
        ss_count  = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_pops(30);
        mon_en = 1'b0;
        abort  = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_eq("abort_outputs", outs1, 64'd0);
        check_eq("restart_stage_start", 64'(ss_count), 64'd1);

        // Reset asserted while in LOAD.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        check_eq("in_load", 64'(stage_start), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_in_load_outputs", outs1, 64'd0);

        // Fresh start after reset begins again at stage 0, tuple (0,0,200).
        exp_q.delete();
        build_stage(0);
        ss_count = 0;
        mon_en   = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_pops(20);
        check_eq("post_rst_stage_start", 64'(ss_count), 64'd1);
        mon_en = 1'b0;
        abort  = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;

        for (int cyc = 0; cyc < 40000 && !t6_finished; cyc++) @(posedge clk);
        check_eq("t6_finished", 64'(t6_finished), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Reduced build runs alongside; sorted_rdy held high so WAIT_SORT exits at once.
    initial begin
        int n2, max_ci, max_st, ssn, exp_n;
        bit seen_done;
        rst2 = 1'b0; start2 = 1'b0; abort2 = 1'b0; sorted2 = 1'b1; ready2 = 1'b1;
        cand_buf2 = '0;
        n2 = 0; max_ci = 0; max_st = 0; ssn = 0; seen_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            @(negedge clk);
            if (done2) begin
                seen_done = 1'b1;
                break;
            end
            if (valid2 && ready2) n2++;
            if (int'(ci2) > max_ci) max_ci = int'(ci2);
            if (int'(st2) > max_st) max_st = int'(st2);
            if (ss2) ssn++;
        end
        exp_n = axis_count(0, TLIM, d_theta[0]) * axis_count(0, PLIM, d_phi[0])
              * axis_count(a_stp[0], ALIM, a_stp[0])
              + 4 * axis_count(0, t_win[1], d_theta[1]) * axis_count(0, p_win[1], d_phi[1])
              * axis_count(a_stp[1], ALIM, a_stp[1]);
        check_eq("t6_done", 64'(seen_done), 64'd1);
        check_eq("t6_tuples", 64'(n2), 64'(exp_n));
        check_eq("t6_max_cand", 64'(max_ci), 64'd3);
        check_eq("t6_max_stage", 64'(max_st), 64'd1);
        check_eq("t6_stage_starts", 64'(ssn), 64'd2);
        t6_finished = 1'b1;
    end

endmodule
